// File: rtl/uart_pixel_packer.sv
// UART byte stream to 12-bit pixel packer.
// Finds the two-byte frame header and packs HI/LO byte pairs into BGR pixels.
// Each pixel is issued as a single-cycle strobe with its index.
// A trailing XOR checksum decides whether the frame ends in DONE or ERROR.
module uart_pixel_packer #(
  parameter int unsigned W       = 50,
  parameter int unsigned H       = 40,
  parameter logic [7:0]  HDR0    = 8'hAA,
  parameter logic [7:0]  HDR1    = 8'h55,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        rx_valid,
  output logic [11:0] rx_data,
  output logic [14:0] pix_index,
  output logic        frame_active,
  output logic        frame_done,
  output logic        frame_error
);

  localparam int unsigned PIX_TOTAL = W * H;
  localparam int          TW        = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [14:0] LAST_PIX  = 15'(PIX_TOTAL - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  // The pixel index is 15 bits wide, so larger images cannot be addressed.
  generate
    if (PIX_TOTAL > 32768 || PIX_TOTAL == 0) begin : g_size_check
      $error("uart_pixel_packer: W*H must be in 1..32768");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR1,
    S_PIX_HI,
    S_PIX_LO,
    S_TRAIL,
    S_DONE,
    S_ERROR
  } state_t;

  state_t        state, state_n;
  logic [3:0]    nibble, nibble_n;
  logic [7:0]    checksum, checksum_n;
  logic [14:0]   pix_cnt, pix_cnt_n;
  logic [TW-1:0] tcount, tcount_n;
  logic          rx_valid_n;
  logic [11:0]   rx_data_n;
  logic [14:0]   pix_index_n;
  logic          counting;

  // Register the FSM state together with the packing datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      nibble    <= '0;
      checksum  <= '0;
      pix_cnt   <= '0;
      tcount    <= '0;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      pix_index <= '0;
    end else begin
      state     <= state_n;
      nibble    <= nibble_n;
      checksum  <= checksum_n;
      pix_cnt   <= pix_cnt_n;
      tcount    <= tcount_n;
      rx_valid  <= rx_valid_n;
      rx_data   <= rx_data_n;
      pix_index <= pix_index_n;
    end
  end

  // Next-state logic: byte-driven transitions, inter-byte timeout, and enable override.
  always_comb begin
    state_n     = state;
    nibble_n    = nibble;
    checksum_n  = checksum;
    pix_cnt_n   = pix_cnt;
    tcount_n    = tcount;
    rx_valid_n  = 1'b0;
    rx_data_n   = rx_data;
    pix_index_n = pix_index;
    counting    = (state == S_HDR1) || (state == S_PIX_HI) ||
                  (state == S_PIX_LO) || (state == S_TRAIL);

    if (!enable) begin
      state_n  = S_IDLE;
      tcount_n = '0;
    end else if (byte_valid) begin
      tcount_n = '0;
      case (state)
        S_IDLE: begin
          if (byte_data == HDR0) state_n = S_HDR1;
        end
        S_HDR1: begin
          if (byte_data == HDR1) begin
            state_n    = S_PIX_HI;
            pix_cnt_n  = '0;
            checksum_n = '0;
          end else if (byte_data != HDR0) begin
            state_n = S_IDLE;
          end
        end
        S_PIX_HI: begin
          nibble_n   = byte_data[3:0];
          checksum_n = checksum ^ byte_data;
          state_n    = S_PIX_LO;
        end
        S_PIX_LO: begin
          rx_data_n   = {nibble, byte_data};
          pix_index_n = pix_cnt;
          rx_valid_n  = 1'b1;
          checksum_n  = checksum ^ byte_data;
          pix_cnt_n   = pix_cnt + 15'd1;
          state_n     = (pix_cnt == LAST_PIX) ? S_TRAIL : S_PIX_HI;
        end
        S_TRAIL: begin
          state_n = (byte_data == checksum) ? S_DONE : S_ERROR;
        end
        default: begin
        end
      endcase
    end else if (counting) begin
      if (tcount == TO_LAST) begin
        state_n  = S_ERROR;
        tcount_n = '0;
      end else begin
        tcount_n = tcount + TW'(1);
      end
    end
  end

  assign frame_active = (state == S_PIX_HI) || (state == S_PIX_LO) || (state == S_TRAIL);
  assign frame_done   = (state == S_DONE);
  assign frame_error  = (state == S_ERROR);

endmodule

// File: tb/tb_uart_pixel_packer.sv
// Bench for uart_pixel_packer: a small 2x1 instance for the directed scenarios
// and a default 50x40 instance for a full random frame. Expected pixels come
// from a scoreboard queue filled as bytes are generated.
module tb_uart_pixel_packer;

  localparam int TO = 200;

  logic clk = 1'b0;
  logic rst_n;

  logic        enable_s, bv_s, rxv_s, act_s, done_s, err_s;
  logic [7:0]  bd_s;
  logic [11:0] rxd_s;
  logic [14:0] pix_s;

  logic        enable_l, bv_l, rxv_l, act_l, done_l, err_l;
  logic [7:0]  bd_l;
  logic [11:0] rxd_l;
  logic [14:0] pix_l;

  typedef struct {
    logic [11:0] data;
    logic [14:0] index;
  } pix_t;

  pix_t exp_s[$];
  pix_t exp_l[$];

  int checks = 0;
  int failures = 0;
  logic [7:0] cs_s, cs_l;
  int idx_s, idx_l;
  int strobes_s = 0;
  int strobes_l = 0;
  logic prev_s = 1'b0;
  logic prev_l = 1'b0;
  logic [11:0] last_d_s = '0;
  logic [14:0] last_i_s = '0;
  int saved;

  // Free-running clock.
  always #5 clk = ~clk;

  uart_pixel_packer #(.W(2), .H(1), .TIMEOUT(TO)) dut_s (
    .clk(clk), .rst_n(rst_n), .enable(enable_s), .byte_valid(bv_s), .byte_data(bd_s),
    .rx_valid(rxv_s), .rx_data(rxd_s), .pix_index(pix_s),
    .frame_active(act_s), .frame_done(done_s), .frame_error(err_s)
  );

  uart_pixel_packer #(.W(50), .H(40), .TIMEOUT(TO)) dut_l (
    .clk(clk), .rst_n(rst_n), .enable(enable_l), .byte_valid(bv_l), .byte_data(bd_l),
    .rx_valid(rxv_l), .rx_data(rxd_l), .pix_index(pix_l),
    .frame_active(act_l), .frame_done(done_l), .frame_error(err_l)
  );

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard: every strobe must match the next expected pixel and never follow another strobe.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rxv_s) begin
        pix_t e;
        strobes_s++;
        check_output("adjacent_s", prev_s, 1'b0);
        check_output("pending_s", exp_s.size() > 0, 1'b1);
        if (exp_s.size() > 0) begin
          e = exp_s.pop_front();
          check_output("rx_data_s", rxd_s, e.data);
          check_output("pix_index_s", pix_s, e.index);
        end
        last_d_s = rxd_s;
        last_i_s = pix_s;
      end
      if (rxv_l) begin
        pix_t e;
        strobes_l++;
        check_output("adjacent_l", prev_l, 1'b0);
        check_output("pending_l", exp_l.size() > 0, 1'b1);
        if (exp_l.size() > 0) begin
          e = exp_l.pop_front();
          check_output("rx_data_l", rxd_l, e.data);
          check_output("pix_index_l", pix_l, e.index);
        end
      end
      prev_s = rxv_s;
      prev_l = rxv_l;
    end else begin
      prev_s = 1'b0;
      prev_l = 1'b0;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input bit big, input logic [7:0] b, input int gap);
    if (big) begin
      bv_l = 1'b1;
      bd_l = b;
    end else begin
      bv_s = 1'b1;
      bd_s = b;
    end
    @(posedge clk);
    #1;
    bv_s = 1'b0;
    bv_l = 1'b0;
    idle(gap);
  endtask

  task automatic header(input bit big);
    if (big) begin
      cs_l = '0;
      idx_l = 0;
    end else begin
      cs_s = '0;
      idx_s = 0;
    end
    send_byte(big, 8'hAA, $urandom_range(0, 2));
    send_byte(big, 8'h55, $urandom_range(0, 2));
  endtask

  task automatic pixel(input bit big, input logic [7:0] hi, input logic [7:0] lo,
                       input int gap);
    pix_t p;
    p.data = {hi[3:0], lo};
    if (big) begin
      p.index = 15'(idx_l);
      exp_l.push_back(p);
      idx_l++;
      cs_l = cs_l ^ hi ^ lo;
    end else begin
      p.index = 15'(idx_s);
      exp_s.push_back(p);
      idx_s++;
      cs_s = cs_s ^ hi ^ lo;
    end
    send_byte(big, hi, gap);
    send_byte(big, lo, gap);
  endtask

  task automatic drop_enable_s();
    enable_s = 1'b0;
    idle(2);
    enable_s = 1'b1;
    idle(1);
  endtask

  // Global time limit so the run always terminates.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios on the small instance, then a full random frame on the large one.
  initial begin
    rst_n = 1'b0;
    enable_s = 1'b0; bv_s = 1'b0; bd_s = '0;
    enable_l = 1'b0; bv_l = 1'b0; bd_l = '0;
    cs_s = '0; cs_l = '0; idx_s = 0; idx_l = 0;
    idle(3);
    check_output("reset_rx_valid", rxv_s, 1'b0);
    check_output("reset_rx_data", rxd_s, 12'h000);
    check_output("reset_pix_index", pix_s, 15'd0);
    check_output("reset_active", act_s, 1'b0);
    check_output("reset_done", done_s, 1'b0);
    check_output("reset_error", err_s, 1'b0);
    check_output("reset_rx_valid_l", rxv_l, 1'b0);
    rst_n = 1'b1;
    idle(2);
    enable_s = 1'b1;
    idle(1);

    // Good two-pixel frame; checksum of 0A BC 03 21 is 0x94.
    header(1'b0);
    check_output("t1_active", act_s, 1'b1);
    pixel(1'b0, 8'h0A, 8'hBC, 1);
    pixel(1'b0, 8'h03, 8'h21, 0);
    check_output("t1_model_checksum", cs_s, 8'h94);
    send_byte(1'b0, cs_s, 0);
    idle(2);
    check_output("t1_done", done_s, 1'b1);
    check_output("t1_error", err_s, 1'b0);
    check_output("t1_active_end", act_s, 1'b0);
    check_output("t1_last_data", last_d_s, 12'h321);
    check_output("t1_last_index", last_i_s, 15'd1);
    check_output("t1_strobes", strobes_s, 2);
    check_output("t1_queue_empty", exp_s.size(), 0);

    // Same pixels, wrong trailer.
    enable_s = 1'b0;
    idle(1);
    check_output("t2_done_cleared", done_s, 1'b0);
    enable_s = 1'b1;
    idle(1);
    header(1'b0);
    pixel(1'b0, 8'h0A, 8'hBC, 0);
    pixel(1'b0, 8'h03, 8'h21, 0);
    send_byte(1'b0, 8'h00, 0);
    idle(2);
    check_output("t2_error", err_s, 1'b1);
    check_output("t2_done", done_s, 1'b0);
    check_output("t2_strobes", strobes_s, 4);
    check_output("t2_queue_empty", exp_s.size(), 0);

    // Resync on a repeated first header byte; long but legal gaps between bytes.
    drop_enable_s();
    send_byte(1'b0, 8'h12, 0);
    send_byte(1'b0, 8'hAA, 0);
    header(1'b0);
    pixel(1'b0, 8'($urandom), 8'($urandom), TO - 1);
    pixel(1'b0, 8'($urandom), 8'($urandom), 1);
    send_byte(1'b0, cs_s, 0);
    idle(2);
    check_output("t3_done", done_s, 1'b1);
    check_output("t3_error", err_s, 1'b0);
    check_output("t3_last_index", last_i_s, 15'd1);
    check_output("t3_queue_empty", exp_s.size(), 0);

    // Inter-byte timeout after a lone HI byte.
    drop_enable_s();
    header(1'b0);
    saved = strobes_s;
    send_byte(1'b0, 8'h0F, 0);
    idle(TO / 2);
    check_output("t4_active_waiting", act_s, 1'b1);
    check_output("t4_no_early_error", err_s, 1'b0);
    idle(TO);
    check_output("t4_error", err_s, 1'b1);
    check_output("t4_active_end", act_s, 1'b0);
    check_output("t4_no_partial", strobes_s, saved);

    // Drop enable mid-frame, bytes ignored while low, then a fresh frame.
    drop_enable_s();
    header(1'b0);
    pixel(1'b0, 8'($urandom), 8'($urandom), 1);
    send_byte(1'b0, 8'($urandom), 2);
    check_output("t5_active_mid", act_s, 1'b1);
    saved = strobes_s;
    enable_s = 1'b0;
    idle(1);
    check_output("t5_active_cleared", act_s, 1'b0);
    check_output("t5_error_cleared", err_s, 1'b0);
    check_output("t5_rx_valid", rxv_s, 1'b0);
    send_byte(1'b0, 8'hAA, 0);
    send_byte(1'b0, 8'h55, 0);
    enable_s = 1'b1;
    idle(1);
    check_output("t5_ignored_while_low", act_s, 1'b0);
    check_output("t5_no_partial", strobes_s, saved);
    header(1'b0);
    pixel(1'b0, 8'($urandom), 8'($urandom), 0);
    pixel(1'b0, 8'($urandom), 8'($urandom), 2);
    send_byte(1'b0, cs_s, 0);
    idle(2);
    check_output("t5_done", done_s, 1'b1);
    check_output("t5_last_index", last_i_s, 15'd1);
    check_output("t5_queue_empty", exp_s.size(), 0);

    // Asynchronous reset in the middle of a frame.
    drop_enable_s();
    header(1'b0);
    send_byte(1'b0, 8'h07, 0);
    rst_n = 1'b0;
    #1;
    check_output("t7_reset_active", act_s, 1'b0);
    check_output("t7_reset_rx_valid", rxv_s, 1'b0);
    idle(1);
    rst_n = 1'b1;
    idle(1);

    // Full default-size frame with random pixels and random byte gaps.
    enable_l = 1'b1;
    idle(1);
    header(1'b1);
    for (int i = 0; i < 2000; i++) begin
      pixel(1'b1, 8'($urandom), 8'($urandom), $urandom_range(0, 2));
    end
    send_byte(1'b1, cs_l, 0);
    idle(3);
    check_output("t6_done", done_l, 1'b1);
    check_output("t6_error", err_l, 1'b0);
    check_output("t6_strobes", strobes_l, 2000);
    check_output("t6_queue_empty", exp_l.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
